// File: rtl/dcache_port_arbiter.sv
// Two-port arbiter for the single data-cache port (MEM stage vs vector LSU).
// Define DCACHE_ARB_RR_EN for round-robin; default is fixed priority with starvation guard.
module dcache_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [1:0]        p0_w_type,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [1:0]        p1_w_type,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              c_req,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_we,
  output logic [1:0]        c_w_type,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_ready,
  input  logic              c_rvalid,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              mem_stall
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [1:0]          w_type_q, w_type_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                win1;
  logic                any_req;

`ifdef DCACHE_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // The port that did not win last time takes ties.
  assign win1 = p1_req & (~p0_req | ~last_owner_q);
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign win1 = p1_req &
    (~p0_req | (starve_q == CNT_W'(STARVE_LIMIT)));
`endif

  assign any_req = p0_req | p1_req;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    w_type_d = w_type_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
`ifdef DCACHE_ARB_RR_EN
    last_owner_d = last_owner_q;
`else
    starve_d = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          p0_gnt   = rst & ~win1;
          p1_gnt   = rst & win1;
          owner_d  = win1;
          addr_d   = win1 ? p1_addr : p0_addr;
          we_d     = win1 ? p1_we : p0_we;
          w_type_d = win1 ? p1_w_type : p0_w_type;
          wdata_d  = win1 ? p1_wdata : p0_wdata;
          state_d  = ISSUE;
`ifdef DCACHE_ARB_RR_EN
          last_owner_d = win1;
`else
          if (win1 || !p1_req) begin
            starve_d = '0;
          end else begin
            starve_d = starve_q + CNT_W'(1);
          end
`endif
        end
      end
      ISSUE: begin
        if (c_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (c_rvalid) begin
          rdata_d = c_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      w_type_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef DCACHE_ARB_RR_EN
      last_owner_q <= 1'b1;
`else
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      w_type_q <= w_type_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef DCACHE_ARB_RR_EN
      last_owner_q <= last_owner_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  assign c_req     = (state_q == ISSUE);
  assign c_addr    = addr_q;
  assign c_we      = we_q;
  assign c_w_type  = w_type_q;
  assign c_wdata   = wdata_q;
  assign rdata     = rdata_q;
  assign p0_rvalid = (state_q == RESP) & ~owner_q;
  assign p1_rvalid = (state_q == RESP) & owner_q;

  // Stall only tracks port-0 ownership; a vector access never freezes MEM.
  assign mem_stall = rst &
    (((state_q == IDLE) & p0_req) |
     (~owner_q & ((state_q == ISSUE) | (state_q == WAIT))));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized bench for dcache_port_arbiter against a transaction-level model.
// Build with DCACHE_ARB_RR_EN defined to exercise the round-robin variant.
module tb_dcache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [1:0]    p0_w_type;
  logic [DW-1:0] p0_wdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [1:0]    p1_w_type;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] rdata;
  logic          c_req, c_we, c_ready, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [1:0]    c_w_type;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          mem_stall;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we),
    .p0_w_type(p0_w_type), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we),
    .p1_w_type(p1_w_type), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata),
    .c_req(c_req), .c_addr(c_addr), .c_we(c_we),
    .c_w_type(c_w_type), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .mem_stall(mem_stall)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: pending requests and arbitration history.
  bit            pend [2];
  logic [AW-1:0] m_addr [2];
  bit            m_we [2];
  logic [1:0]    m_wt [2];
  logic [DW-1:0] m_wd [2];
  int            starve = 0;
  int            last = 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic req_set(input int p, input logic [AW-1:0] a,
                         input bit we, input logic [1:0] wt,
                         input logic [DW-1:0] wd);
    pend[p]   = 1'b1;
    m_addr[p] = a;
    m_we[p]   = we;
    m_wt[p]   = wt;
    m_wd[p]   = wd;
  endtask

  task automatic req_rand(input int p);
    bit we;
    if (!pend[p]) begin
      we = 1'($urandom % 2);
      req_set(p, $urandom, we, we ? 2'($urandom % 4) : 2'b00,
              rnd_line());
    end
  endtask

  task automatic drive_ports();
    p0_req    = pend[0];
    p0_addr   = m_addr[0];
    p0_we     = m_we[0];
    p0_w_type = m_wt[0];
    p0_wdata  = m_wd[0];
    p1_req    = pend[1];
    p1_addr   = m_addr[1];
    p1_we     = m_we[1];
    p1_w_type = m_wt[1];
    p1_wdata  = m_wd[1];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, c_req, c_we,
         c_w_type, mem_stall}, '0);
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_caddr"}, c_addr, '0);
    chk({tag, "_cwdata"}, c_wdata, '0);
  endtask

  // One full transaction starting in IDLE; returns the port the DUT granted.
  task automatic run_txn(input int rd, input int wdl,
                         input logic [DW-1:0] line, output int obs_win);
    int            win;
    logic [AW-1:0] ea;
    bit            ewe;
    logic [1:0]    ewt;
    logic [DW-1:0] ewd;
    @(negedge clk);
    drive_ports();
    c_ready  = 1'($urandom % 2);
    c_rvalid = 1'($urandom % 2);
    c_rdata  = rnd_line();
    if (pend[0] && pend[1]) begin
`ifdef DCACHE_ARB_RR_EN
      win = (last == 1) ? 0 : 1;
`else
      win = (starve == SL) ? 1 : 0;
`endif
    end else begin
      win = pend[0] ? 0 : 1;
    end
    if (win == 0 && pend[1]) starve++;
    else starve = 0;
    last = win;
    #1;
    obs_win = p1_gnt ? 1 : 0;
    chk("gnt0", p0_gnt, win == 0);
    chk("gnt1", p1_gnt, win == 1);
    chk("stall_idle", mem_stall, pend[0]);
    chk("creq_idle", c_req, 1'b0);
    ea  = m_addr[win];
    ewe = m_we[win];
    ewt = m_wt[win];
    ewd = m_wd[win];
    pend[win] = 1'b0;
    for (int k = 0; k <= rd; k++) begin
      @(negedge clk);
      drive_ports();
      c_ready  = (k == rd);
      c_rvalid = 1'($urandom % 2);
      c_rdata  = rnd_line();
      #1;
      chk("creq_issue", c_req, 1'b1);
      chk("caddr", c_addr, ea);
      chk("cwe_wt", {c_we, c_w_type}, {ewe, ewt});
      chk("cwdata", c_wdata, ewd);
      chk("stall_issue", mem_stall, win == 0);
      chk("side_issue", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, '0);
    end
    for (int k = 0; k <= wdl; k++) begin
      @(negedge clk);
      drive_ports();
      c_ready  = 1'($urandom % 2);
      c_rvalid = (k == wdl);
      c_rdata  = (k == wdl) ? line : rnd_line();
      #1;
      chk("creq_wait", c_req, 1'b0);
      chk("caddr_wait", c_addr, ea);
      chk("stall_wait", mem_stall, win == 0);
      chk("side_wait", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, '0);
    end
    @(negedge clk);
    drive_ports();
    c_ready  = 1'b0;
    c_rvalid = 1'($urandom % 2);
    c_rdata  = rnd_line();
    #1;
    chk("rvalid0", p0_rvalid, win == 0);
    chk("rvalid1", p1_rvalid, win == 1);
    chk("stall_resp", mem_stall, 1'b0);
    chk("side_resp", {p0_gnt, p1_gnt, c_req}, '0);
    if (!ewe) chk("rdata", rdata, line);
  endtask

  logic [DW-1:0] dead_line;
  logic [5:0]    seq_obs, seq_exp;
  int            w;

  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = '0; m_we[p] = 1'b0; m_wt[p] = '0; m_wd[p] = '0;
    end
    drive_ports();
    p0_req   = 1'b1;
    c_ready  = 1'b0;
    c_rvalid = 1'b0;
    c_rdata  = '0;
    rst      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero("reset");
    drive_ports();
    rst = 1'b1;

    // Minimum-latency port-0 read.
    dead_line = 128'hDEAD0000_00000000_00000000_00000001;
    req_set(0, 32'h0000_1040, 1'b0, 2'b00, '0);
    run_txn(0, 0, dead_line, w);

    // Simultaneous requests: p0 first, then p1 with its own line.
    req_rand(0);
    req_rand(1);
    run_txn(0, 1, rnd_line(), w);
    run_txn(1, 0, rnd_line(), w);

    // Both held continuously.
    for (int i = 0; i < 6; i++) begin
      req_rand(0);
      req_rand(1);
      run_txn(0, 0, rnd_line(), w);
      seq_obs[i] = w[0];
    end
`ifdef DCACHE_ARB_RR_EN
    seq_exp = 6'b101010;
`else
    seq_exp = 6'b010000;
`endif
    chk("grant_seq", seq_obs, seq_exp);
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Slow accept plus long miss on port 0.
    req_set(0, $urandom, 1'b0, 2'b00, rnd_line());
    run_txn(3, 20, rnd_line(), w);

    // 128-bit write from the vector unit.
    req_set(1, 32'hCAFE_0000, 1'b1, 2'b11, rnd_line());
    run_txn(0, 2, rnd_line(), w);

    for (int i = 0; i < 40; i++) begin
      if ($urandom % 2 != 0) req_rand(0);
      if ($urandom % 2 != 0) req_rand(1);
      if (!pend[0] && !pend[1]) req_rand($urandom % 2);
      run_txn($urandom_range(0, 3),
              ($urandom % 8 == 0) ? 20 : $urandom_range(0, 4),
              rnd_line(), w);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Reset in WAIT abandons the access.
    req_set(0, $urandom, 1'b0, 2'b00, rnd_line());
    @(negedge clk);
    drive_ports();
    pend[0] = 1'b0;
    c_ready = 1'b1;
    @(negedge clk);
    drive_ports();
    @(negedge clk);
    c_ready = 1'b0;
    #1;
    chk("wait_before_rst", {c_req, mem_stall}, 2'b01);
    rst = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    c_rvalid = 1'b1;
    c_rdata  = rnd_line();
    #1;
    chk_zero("mid_reset");
    starve = 0;
    last   = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c_rvalid = 1'b1;
      c_rdata  = rnd_line();
      #1;
      chk("stray_rvalid", {p0_rvalid, p1_rvalid, c_req}, '0);
    end
    c_rvalid = 1'b0;

    req_rand(0);
    req_rand(1);
    run_txn(1, 1, rnd_line(), w);
    run_txn(0, 0, rnd_line(), w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
